button_debounce: RTL and testbench



---
 rtl/btn_pkg.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/button_debounce.sv | 137 +++++++++++++
 tb/tb_button_debounce.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and board-level defaults for the push-button conditioning logic.
// The defaults give a 20 ms debounce window and a 1 s long-press time at 27 MHz.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_DBNC,
    HELD,
    RELEASE_DBNC
  } btn_state_e;

  localparam int CLK_HZ               = 27000000;
  localparam int DEFAULT_DEBOUNCE_CYC = CLK_HZ / 50;
  localparam int DEFAULT_LONG_CYC     = CLK_HZ;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
// RESET_VAL lets each pin start at its own idle level, so reset never looks like activity.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Conditions a raw push-button pin: synchronises it, debounces both edges, and produces
// a clean pressed level plus one-cycle press, release and long-press pulses.
module button_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEFAULT_LONG_CYC,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic iBTN,
  output logic oLevel,
  output logic oPress,
  output logic oRelease,
  output logic oLong
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic PIN_IDLE = ACTIVE_LOW;

  logic pinSync;
  logic sAct;

  btn_state_e    state_q, state_d;
  logic [DW-1:0] dbncCnt_q, dbncCnt_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  sync_2ff #(
    .RESET_VAL(PIN_IDLE)
  ) uPinSync (
    .clk_i (CLK),
    .rst_ni(RESETn),
    .d_i   (iBTN),
    .q_o   (pinSync)
  );

  assign sAct = ACTIVE_LOW ? ~pinSync : pinSync;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= RELEASED;
      dbncCnt_q <= '0;
      holdCnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dbncCnt_q <= dbncCnt_d;
      holdCnt_q <= holdCnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dbncCnt_d = dbncCnt_q;
    holdCnt_d = holdCnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    // The hold counter runs for as long as the press is accepted, including release debounce.
    if (state_q == HELD || state_q == RELEASE_DBNC) begin
      if (holdCnt_q != HOLD_MAX) begin
        holdCnt_d = holdCnt_q + 1'b1;
      end
      long_d = (holdCnt_q == HOLD_LAST);
    end

    unique case (state_q)
      RELEASED: begin
        if (sAct) begin
          state_d   = PRESS_DBNC;
          dbncCnt_d = '0;
        end
      end
      PRESS_DBNC: begin
        if (!sAct) begin
          state_d = RELEASED;
        end else if (dbncCnt_q == DB_LAST) begin
          state_d   = HELD;
          level_d   = 1'b1;
          press_d   = 1'b1;
          holdCnt_d = '0;
        end else begin
          dbncCnt_d = dbncCnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sAct) begin
          state_d   = RELEASE_DBNC;
          dbncCnt_d = '0;
        end
      end
      RELEASE_DBNC: begin
        if (sAct) begin
          state_d = HELD;
        end else if (dbncCnt_q == DB_LAST) begin
          state_d   = RELEASED;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          dbncCnt_d = dbncCnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
      end
    endcase

    // An accepted release ends the press, so a long-press pulse in the same cycle is dropped.
    if (release_d) begin
      long_d = 1'b0;
    end
  end

  assign oLevel   = level_q;
  assign oPress   = press_q;
  assign oRelease = release_q;
  assign oLong    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with short debounce/long-press windows.
// Edge k is the k-th rising clock edge after iBTN changes; outputs are sampled on the following falling edge.
module tb_button_debounce;

  localparam int DB   = 4;
  localparam int LONG = 20;

  logic CLK;
  logic RESETn;
  logic iBTN;
  logic oLevel;
  logic oPress;
  logic oRelease;
  logic oLong;

  int errors;
  int checks;

  button_debounce #(
    .DEBOUNCE_CYC(DB),
    .LONG_CYC    (LONG),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .iBTN    (iBTN),
    .oLevel  (oLevel),
    .oPress  (oPress),
    .oRelease(oRelease),
    .oLong   (oLong)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic stepEdge();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic pin, input int cycles);
    iBTN = pin;
    for (int i = 0; i < cycles; i++) stepEdge();
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    RESETn = 1'b0;
    iBTN   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      stepEdge();
      exp = 4'b0000;
      checks++;
      if ({oLevel, oPress, oRelease, oLong} !== exp) begin
        errors++;
        $display("[TB] FAIL reset k=%0d got={lvl,prs,rel,lng}=%b exp=%b", k,
                 {oLevel, oPress, oRelease, oLong}, exp);
      end
    end
    RESETn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      stepEdge();
      exp = 4'b0000;
      checks++;
      if ({oLevel, oPress, oRelease, oLong} !== exp) begin
        errors++;
        $display("[TB] FAIL reset_idle k=%0d got=%b exp=%b", k, {oLevel, oPress, oRelease, oLong}, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp;
    iBTN = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      stepEdge();
      exp = {(k >= 7), (k == 7), 1'b0, 1'b0};
      checks++;
      if ({oLevel, oPress, oRelease, oLong} !== exp) begin
        errors++;
        $display("[TB] FAIL clean_press k=%0d got=%b exp=%b", k, {oLevel, oPress, oRelease, oLong}, exp);
      end
    end
    iBTN = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      stepEdge();
      exp = {(k < 7), 1'b0, (k == 7), 1'b0};
      checks++;
      if ({oLevel, oPress, oRelease, oLong} !== exp) begin
        errors++;
        $display("[TB] FAIL clean_release k=%0d got=%b exp=%b", k, {oLevel, oPress, oRelease, oLong}, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp;
    iBTN = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 4) iBTN = 1'b1;
      stepEdge();
      exp = 4'b0000;
      checks++;
      if ({oLevel, oPress, oRelease, oLong} !== exp) begin
        errors++;
        $display("[TB] FAIL bounce k=%0d got=%b exp=%b", k, {oLevel, oPress, oRelease, oLong}, exp);
      end
    end
  endtask

  task automatic test_long_press();
    logic [3:0] exp;
    int longCount;
    longCount = 0;
    iBTN = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      stepEdge();
      if (oLong === 1'b1) longCount++;
      exp = {(k >= 7), (k == 7), 1'b0, (k == 7 + LONG)};
      checks++;
      if ({oLevel, oPress, oRelease, oLong} !== exp) begin
        errors++;
        $display("[TB] FAIL long_press k=%0d got=%b exp=%b", k, {oLevel, oPress, oRelease, oLong}, exp);
      end
    end
    iBTN = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      stepEdge();
      if (oLong === 1'b1) longCount++;
      exp = {(k < 7), 1'b0, (k == 7), 1'b0};
      checks++;
      if ({oLevel, oPress, oRelease, oLong} !== exp) begin
        errors++;
        $display("[TB] FAIL long_release k=%0d got=%b exp=%b", k, {oLevel, oPress, oRelease, oLong}, exp);
      end
    end
    checks++;
    if (longCount !== 1) begin
      errors++;
      $display("[TB] FAIL long_count got=%0d exp=1", longCount);
    end
  endtask

  task automatic test_release_glitch();
    logic [3:0] exp;
    iBTN = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 11) iBTN = 1'b1;
      if (k == 13) iBTN = 1'b0;
      stepEdge();
      exp = {(k >= 7), (k == 7), 1'b0, (k == 7 + LONG)};
      checks++;
      if ({oLevel, oPress, oRelease, oLong} !== exp) begin
        errors++;
        $display("[TB] FAIL glitch k=%0d got=%b exp=%b", k, {oLevel, oPress, oRelease, oLong}, exp);
      end
    end
    iBTN = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      stepEdge();
      exp = {(k < 7), 1'b0, (k == 7), 1'b0};
      checks++;
      if ({oLevel, oPress, oRelease, oLong} !== exp) begin
        errors++;
        $display("[TB] FAIL glitch_release k=%0d got=%b exp=%b", k, {oLevel, oPress, oRelease, oLong}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_held();
    logic [3:0] exp;
    iBTN = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      stepEdge();
      exp = {(k >= 7), (k == 7), 1'b0, 1'b0};
      checks++;
      if ({oLevel, oPress, oRelease, oLong} !== exp) begin
        errors++;
        $display("[TB] FAIL mid_press k=%0d got=%b exp=%b", k, {oLevel, oPress, oRelease, oLong}, exp);
      end
    end
    RESETn = 1'b0;
    #1;
    checks++;
    if ({oLevel, oPress, oRelease, oLong} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL async_drop got=%b exp=0000", {oLevel, oPress, oRelease, oLong});
    end
    stepEdge();
    checks++;
    if ({oLevel, oPress, oRelease, oLong} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL in_reset got=%b exp=0000", {oLevel, oPress, oRelease, oLong});
    end
    RESETn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      stepEdge();
      exp = {(k >= 7), (k == 7), 1'b0, 1'b0};
      checks++;
      if ({oLevel, oPress, oRelease, oLong} !== exp) begin
        errors++;
        $display("[TB] FAIL repress k=%0d got=%b exp=%b", k, {oLevel, oPress, oRelease, oLong}, exp);
      end
    end
    iBTN = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      stepEdge();
      exp = {(k < 7), 1'b0, (k == 7), 1'b0};
      checks++;
      if ({oLevel, oPress, oRelease, oLong} !== exp) begin
        errors++;
        $display("[TB] FAIL repress_release k=%0d got=%b exp=%b", k, {oLevel, oPress, oRelease, oLong}, exp);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RESETn = 1'b0;
    iBTN   = 1'b1;
    @(negedge CLK);
    test_reset();
    test_clean_press();
    applyStimulus(1'b1, 5);
    test_bounce();
    applyStimulus(1'b1, 5);
    test_long_press();
    applyStimulus(1'b1, 5);
    test_release_glitch();
    applyStimulus(1'b1, 5);
    test_reset_mid_held();
    applyStimulus(1'b1, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
